mac_tile_mw: RTL and testbench

MAC_TILE_MW -- requirements
Module: mac_tile_mw

---
 rtl/mac_tile_mw.sv | 132 +++++++++++++
 tb/tb_mac_tile_mw.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tile_mw.sv
// mac_tile_mw: one tile of a dual-mode (weight-/output-stationary) systolic MAC array.
//
// Parameters
//   bw      activation/weight width (signed)
//   psum_bw partial-sum/accumulator width (signed, > 2*bw)
//   wdepth  weight-bank entries (power of 2, >= 2)
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   mode_select           0 = weight-stationary, 1 = output-stationary
//   in_w, inst_w, wsel_w  activation, instruction {drain, execute, load}, bank index from west
//   in_n, valid_n         partial sum / weight and drain-valid from north
//   out_e, inst_e, wsel_e registered east copies
//   out_s, valid_s        registered south data and drain-valid
//   load_full             every weight-bank entry has been written
module mac_tile_mw #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int wdepth  = 4,
  localparam int iw     = $clog2(wdepth)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode_select,
  input  logic [bw-1:0]      in_w,
  input  logic [2:0]         inst_w,
  input  logic [iw-1:0]      wsel_w,
  input  logic [psum_bw-1:0] in_n,
  input  logic               valid_n,
  output logic [bw-1:0]      out_e,
  output logic [2:0]         inst_e,
  output logic [iw-1:0]      wsel_e,
  output logic [psum_bw-1:0] out_s,
  output logic               valid_s,
  output logic               load_full
);

  localparam logic [0:0] st_acc     = 1'b0;
  localparam logic [0:0] st_drained = 1'b1;

  logic [bw-1:0]      wbank [wdepth];
  logic [iw-1:0]      lptr;
  logic [psum_bw-1:0] acc;
  logic               mode_q;
  logic [0:0]         os_state;

  logic               mode_chg;
  logic [psum_bw-1:0] a_ext, wws_ext, wos_ext;
  logic [psum_bw-1:0] prod_ws, prod_os;

  assign mode_chg = mode_select != mode_q;

  // Operands are sign-extended to psum_bw before multiplying; the exact product
  // fits in 2*bw bits, so the psum_bw-wide result equals its sign extension.
  assign a_ext   = {{(psum_bw-bw){in_w[bw-1]}}, in_w};
  assign wws_ext = {{(psum_bw-bw){wbank[wsel_w][bw-1]}}, wbank[wsel_w]};
  assign wos_ext = {{(psum_bw-bw){in_n[bw-1]}}, in_n[bw-1:0]};
  assign prod_ws = a_ext * wws_ext;
  assign prod_os = a_ext * wos_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_s     <= '0;
      valid_s   <= 1'b0;
      out_e     <= '0;
      inst_e    <= '0;
      wsel_e    <= '0;
      load_full <= 1'b0;
      lptr      <= '0;
      acc       <= '0;
      mode_q    <= 1'b0;
      os_state  <= st_acc;
      for (int i = 0; i < wdepth; i++) wbank[i] <= '0;
    end else begin
      inst_e[2:1] <= inst_w[2:1];
      // Loads pass east only once this tile's bank is full.
      inst_e[0]   <= load_full & inst_w[0];
      mode_q      <= mode_select;

      if (mode_chg) begin
        acc       <= '0;
        lptr      <= '0;
        load_full <= 1'b0;
        os_state  <= st_acc;
        valid_s   <= 1'b0;
      end else begin
        if (inst_w[1] || inst_w[0]) begin
          out_e  <= in_w;
          wsel_e <= wsel_w;
        end

        if (!mode_q) begin
          // Weight-stationary. The execute read uses the pre-write bank value.
          if (inst_w[0] && !load_full) begin
            wbank[lptr] <= in_w;
            lptr        <= lptr + iw'(1);
            if (lptr == iw'(wdepth - 1)) load_full <= 1'b1;
          end
          if (inst_w[1]) begin
            out_s   <= in_n + prod_ws;
            valid_s <= 1'b0;
          end
        end else if (os_state == st_acc) begin
          if (inst_w[2]) begin
            out_s    <= inst_w[1] ? acc + prod_os : acc;
            valid_s  <= 1'b1;
            acc      <= '0;
            os_state <= st_drained;
          end else if (inst_w[1]) begin
            acc     <= acc + prod_os;
            out_s   <= wos_ext;
            valid_s <= 1'b0;
          end
        end else begin
          // Drained: forward upstream results until drain drops.
          if (inst_w[2]) begin
            out_s   <= in_n;
            valid_s <= valid_n;
          end else begin
            valid_s  <= 1'b0;
            os_state <= st_acc;
            if (inst_w[1]) begin
              acc   <= acc + prod_os;
              out_s <= wos_ext;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_tile_mw.sv
// tb_mac_tile_mw: directed scoreboard bench for mac_tile_mw (bw=4, psum_bw=16, wdepth=4).
module tb_mac_tile_mw;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode_select = 1'b0;
  logic [3:0]  in_w = '0;
  logic [2:0]  inst_w = '0;
  logic [1:0]  wsel_w = '0;
  logic [15:0] in_n = '0;
  logic        valid_n = 1'b0;
  logic [3:0]  out_e;
  logic [2:0]  inst_e;
  logic [1:0]  wsel_e;
  logic [15:0] out_s;
  logic        valid_s;
  logic        load_full;

  int checks = 0;
  int errors = 0;

  // Field selectors for the scoreboard
  localparam int FOutS = 0, FValid = 1, FFull = 2, FInstE = 3, FOutE = 4, FWselE = 5;

  string       tag_q[$];
  int          fld_q[$];
  logic [15:0] val_q[$];

  mac_tile_mw #(.bw(4), .psum_bw(16), .wdepth(4)) dut (
    .clk(clk), .reset(reset), .mode_select(mode_select),
    .in_w(in_w), .inst_w(inst_w), .wsel_w(wsel_w), .in_n(in_n), .valid_n(valid_n),
    .out_e(out_e), .inst_e(inst_e), .wsel_e(wsel_e),
    .out_s(out_s), .valid_s(valid_s), .load_full(load_full)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] obs(int f);
    case (f)
      FOutS:   return out_s;
      FValid:  return {15'b0, valid_s};
      FFull:   return {15'b0, load_full};
      FInstE:  return {13'b0, inst_e};
      FOutE:   return {12'b0, out_e};
      FWselE:  return {14'b0, wsel_e};
      default: return 16'hdead;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int f, input logic [15:0] v);
    tag_q.push_back(tag);
    fld_q.push_back(f);
    val_q.push_back(v);
  endtask

  task automatic flush();
    string t;
    int f;
    logic [15:0] v;
    while (tag_q.size() > 0) begin
      t = tag_q.pop_front();
      f = fld_q.pop_front();
      v = val_q.pop_front();
      check_val(t, obs(f), v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    flush();
  endtask

  task automatic drv(input logic m, input logic [2:0] inst, input logic [3:0] a,
                     input logic [1:0] ws, input logic [15:0] n, input logic vn);
    mode_select = m;
    inst_w = inst;
    in_w = a;
    wsel_w = ws;
    in_n = n;
    valid_n = vn;
  endtask

  logic [15:0] bank_exp [4];
  logic [3:0]  load_vals [4];

  initial begin
    bank_exp  = '{16'h0001, 16'hFFFE, 16'h0003, 16'hFFF8};
    load_vals = '{4'h1, 4'hE, 4'h3, 4'h8};

    // Asynchronous reset, checked between edges
    #2 reset = 1'b0;
    #1;
    push_exp("rst_out_s", FOutS, 16'h0);
    push_exp("rst_valid", FValid, 16'h0);
    push_exp("rst_full", FFull, 16'h0);
    push_exp("rst_inst_e", FInstE, 16'h0);
    push_exp("rst_out_e", FOutE, 16'h0);
    push_exp("rst_wsel_e", FWselE, 16'h0);
    flush();
    repeat (2) @(posedge clk);
    #1;
    drv(1'b0, 3'b000, 4'h0, 2'd0, 16'h0, 1'b0);
    reset = 1'b1;

    // WS load of four weights; bank absorbs loads, nothing passes east
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 3'b001, load_vals[i], 2'd0, 16'h0, 1'b0);
      push_exp("ld_inst_e", FInstE, 16'h0);
      push_exp("ld_out_e", FOutE, {12'b0, load_vals[i]});
      push_exp("ld_full", FFull, (i == 3) ? 16'h1 : 16'h0);
      tick();
    end
    // Fifth load passes east
    drv(1'b0, 3'b001, 4'h5, 2'd0, 16'h0, 1'b0);
    push_exp("ld5_inst_e", FInstE, 16'h1);
    push_exp("ld5_full", FFull, 16'h1);
    tick();
    // Bank contents unchanged by fifth load
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 3'b010, 4'h1, 2'(i), 16'h0, 1'b0);
      push_exp("bank_rd", FOutS, bank_exp[i]);
      push_exp("bank_wsel_e", FWselE, 16'(i));
      push_exp("bank_inst_e", FInstE, 16'h2);
      tick();
    end
    // -3 * -8 + 100 = 124
    drv(1'b0, 3'b010, 4'hD, 2'd3, 16'd100, 1'b0);
    push_exp("ws_mac", FOutS, 16'd124);
    push_exp("ws_out_e", FOutE, 16'hD);
    push_exp("ws_wsel_e", FWselE, 16'h3);
    push_exp("ws_valid", FValid, 16'h0);
    tick();
    // Idle holds
    drv(1'b0, 3'b000, 4'h5, 2'd1, 16'd999, 1'b0);
    push_exp("idle_out_s", FOutS, 16'd124);
    push_exp("idle_out_e", FOutE, 16'hD);
    push_exp("idle_inst_e", FInstE, 16'h0);
    tick();

    // Mode change WS->OS: state cleared, inst_w ignored except inst_e
    drv(1'b1, 3'b010, 4'h3, 2'd1, 16'd2, 1'b0);
    push_exp("mc_full", FFull, 16'h0);
    push_exp("mc_valid", FValid, 16'h0);
    push_exp("mc_out_s", FOutS, 16'd124);
    push_exp("mc_inst_e", FInstE, 16'h2);
    tick();
    drv(1'b1, 3'b100, 4'h0, 2'd0, 16'h0, 1'b0);
    push_exp("mc_drain", FOutS, 16'h0);
    push_exp("mc_drain_v", FValid, 16'h1);
    push_exp("mc_drain_ie", FInstE, 16'h4);
    tick();
    drv(1'b1, 3'b000, 4'h0, 2'd0, 16'h0, 1'b0);
    push_exp("mc_idle_v", FValid, 16'h0);
    tick();

    // OS accumulate (2,3),(-1,5),(7,-8) = -55
    drv(1'b1, 3'b010, 4'h2, 2'd0, 16'd3, 1'b0);
    push_exp("os_fwd1", FOutS, 16'd3);
    push_exp("os_v1", FValid, 16'h0);
    tick();
    drv(1'b1, 3'b010, 4'hF, 2'd0, 16'd5, 1'b0);
    push_exp("os_fwd2", FOutS, 16'd5);
    tick();
    drv(1'b1, 3'b010, 4'h7, 2'd0, 16'hFFF8, 1'b0);
    push_exp("os_fwd3", FOutS, 16'hFFF8);
    tick();
    drv(1'b1, 3'b100, 4'h0, 2'd0, 16'h0, 1'b0);
    push_exp("os_drain", FOutS, 16'hFFC9);
    push_exp("os_drain_v", FValid, 16'h1);
    tick();
    drv(1'b1, 3'b100, 4'h0, 2'd0, 16'h1234, 1'b1);
    push_exp("os_pass", FOutS, 16'h1234);
    push_exp("os_pass_v", FValid, 16'h1);
    tick();
    drv(1'b1, 3'b000, 4'h0, 2'd0, 16'h0, 1'b0);
    push_exp("os_end_v", FValid, 16'h0);
    push_exp("os_end_hold", FOutS, 16'h1234);
    tick();
    drv(1'b1, 3'b100, 4'h0, 2'd0, 16'h0, 1'b0);
    push_exp("os_acc0", FOutS, 16'h0);
    push_exp("os_acc0_v", FValid, 16'h1);
    tick();
    drv(1'b1, 3'b000, 4'h0, 2'd0, 16'h0, 1'b0);
    push_exp("os_end2_v", FValid, 16'h0);
    tick();
    // Drain with same-cycle execute: 3*4 + 2*5 = 22
    drv(1'b1, 3'b010, 4'h3, 2'd0, 16'd4, 1'b0);
    push_exp("os_fwd4", FOutS, 16'd4);
    tick();
    drv(1'b1, 3'b110, 4'h2, 2'd0, 16'd5, 1'b0);
    push_exp("os_drain_ex", FOutS, 16'd22);
    push_exp("os_drain_ex_v", FValid, 16'h1);
    tick();
    // Drained, drain low, execute accumulates from zero
    drv(1'b1, 3'b010, 4'h1, 2'd0, 16'd6, 1'b0);
    push_exp("os_re_fwd", FOutS, 16'd6);
    push_exp("os_re_v", FValid, 16'h0);
    tick();
    drv(1'b1, 3'b100, 4'h0, 2'd0, 16'h0, 1'b0);
    push_exp("os_re_drain", FOutS, 16'd6);
    push_exp("os_re_drain_v", FValid, 16'h1);
    tick();
    drv(1'b1, 3'b000, 4'h0, 2'd0, 16'h0, 1'b0);
    tick();

    // Back to WS: bank kept, pointer cleared
    drv(1'b0, 3'b000, 4'h0, 2'd0, 16'h0, 1'b0);
    push_exp("ws2_full", FFull, 16'h0);
    push_exp("ws2_valid", FValid, 16'h0);
    tick();
    // Load + execute together uses pre-write weight (1): 7*1 = 7
    drv(1'b0, 3'b011, 4'h7, 2'd0, 16'h0, 1'b0);
    push_exp("ldex_out_s", FOutS, 16'd7);
    push_exp("ldex_inst_e", FInstE, 16'h2);
    push_exp("ldex_full", FFull, 16'h0);
    tick();
    // Partially loaded bank: entry 1 still old
    drv(1'b0, 3'b010, 4'h1, 2'd1, 16'h0, 1'b0);
    push_exp("part_rd", FOutS, 16'hFFFE);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 3'b001, 4'h7, 2'd0, 16'h0, 1'b0);
      push_exp("ld2_full", FFull, (i == 2) ? 16'h1 : 16'h0);
      tick();
    end
    drv(1'b0, 3'b010, 4'h1, 2'd0, 16'h0, 1'b0);
    push_exp("ld2_rd0", FOutS, 16'd7);
    tick();
    // Wrap: 0x7FF0 + 49 = 0x8021
    drv(1'b0, 3'b010, 4'h7, 2'd2, 16'h7FF0, 1'b0);
    push_exp("ws_wrap", FOutS, 16'h8021);
    tick();

    // Reset asserted mid-drain
    drv(1'b1, 3'b000, 4'h0, 2'd0, 16'h0, 1'b0);
    tick();
    drv(1'b1, 3'b010, 4'h2, 2'd1, 16'd3, 1'b0);
    push_exp("os3_fwd", FOutS, 16'd3);
    tick();
    drv(1'b1, 3'b100, 4'h0, 2'd0, 16'h0, 1'b0);
    push_exp("os3_drain", FOutS, 16'd6);
    push_exp("os3_drain_v", FValid, 16'h1);
    tick();
    drv(1'b1, 3'b100, 4'h0, 2'd0, 16'h1234, 1'b1);
    #2 reset = 1'b0;
    #1;
    push_exp("mrst_out_s", FOutS, 16'h0);
    push_exp("mrst_valid", FValid, 16'h0);
    push_exp("mrst_full", FFull, 16'h0);
    push_exp("mrst_out_e", FOutE, 16'h0);
    push_exp("mrst_wsel_e", FWselE, 16'h0);
    push_exp("mrst_inst_e", FInstE, 16'h0);
    flush();
    push_exp("mrst_hold_s", FOutS, 16'h0);
    push_exp("mrst_hold_v", FValid, 16'h0);
    tick();
    drv(1'b0, 3'b000, 4'h0, 2'd0, 16'h0, 1'b0);
    reset = 1'b1;
    // Bank cleared by reset: 1*0 + 5 = 5
    drv(1'b0, 3'b010, 4'h1, 2'd2, 16'd5, 1'b0);
    push_exp("post_rst_rd", FOutS, 16'd5);
    push_exp("post_rst_full", FFull, 16'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
